// File: rtl/synth_pkg.sv
// Shared types and constants for the voice scheduler and its multiplier arbiter.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } frame_state_e;

    typedef enum logic {
        MIDLE = 1'b0,
        MBUSY = 1'b1
    } mul_state_e;

    localparam logic OWNER_ENV   = 1'b0;
    localparam logic OWNER_AUX   = 1'b1;
    localparam int   VOICE_IDX_W = 2;

endpackage

// File: rtl/mul_arbiter.sv
// Two-requester round-robin arbiter for the shared multiplier, with one pending latch per requester.
module mul_arbiter
    import synth_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic env_req,
    input  logic aux_req,
    input  logic mul_done,
    output logic env_ready,
    output logic aux_ready,
    output logic mul_start,
    output logic mul_owner
);

    mul_state_e state, state_n;
    logic env_pend, aux_pend, last_owner;
    logic env_want, aux_want, grant, grantee, finish;

    // A request on the grant cycle counts directly, giving one-cycle request-to-start latency.
    always_comb begin
        env_want = env_pend | env_req;
        aux_want = aux_pend | aux_req;
        state_n  = state;
        grant    = 1'b0;
        grantee  = OWNER_ENV;
        finish   = 1'b0;
        case (state)
            MIDLE: begin
                if (env_want || aux_want) begin
                    grant   = 1'b1;
                    state_n = MBUSY;
                    if (env_want && aux_want) grantee = ~last_owner;
                    else                      grantee = aux_want ? OWNER_AUX : OWNER_ENV;
                end
            end
            MBUSY: begin
                if (mul_done) begin
                    finish  = 1'b1;
                    state_n = MIDLE;
                end
            end
            default: state_n = MIDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MIDLE;
            env_pend   <= 1'b0;
            aux_pend   <= 1'b0;
            last_owner <= OWNER_AUX;
            mul_owner  <= OWNER_ENV;
            mul_start  <= 1'b0;
            env_ready  <= 1'b0;
            aux_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            mul_start <= grant;
            env_ready <= finish && (mul_owner == OWNER_ENV);
            aux_ready <= finish && (mul_owner == OWNER_AUX);
            if (grant)  mul_owner  <= grantee;
            if (finish) last_owner <= mul_owner;
            // A fresh request from the finishing owner survives the clear.
            env_pend <= (finish && mul_owner == OWNER_ENV) ? env_req : env_want;
            aux_pend <= (finish && mul_owner == OWNER_AUX) ? aux_req : aux_want;
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Per-sample frame sequencer: walks each voice through the envelope unit and hosts the multiplier arbiter.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 3,
    parameter int ENV_TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sample_tick_i,
    input  logic [NUM_VOICES-1:0]    gate_i,
    input  logic [4*NUM_VOICES-1:0]  attack_i,
    input  logic [4*NUM_VOICES-1:0]  decay_i,
    input  logic [4*NUM_VOICES-1:0]  sustain_i,
    input  logic [4*NUM_VOICES-1:0]  release_i,
    output logic                     env_start_o,
    output logic [VOICE_IDX_W-1:0]   env_voice_o,
    output logic                     env_gate_o,
    output logic [3:0]               env_attack_o,
    output logic [3:0]               env_decay_o,
    output logic [3:0]               env_sustain_o,
    output logic [3:0]               env_release_o,
    input  logic                     env_ready_i,
    input  logic                     env_mult_req_i,
    output logic                     env_mult_ready_o,
    input  logic                     aux_mult_req_i,
    output logic                     aux_mult_ready_o,
    output logic                     mul_start_o,
    output logic                     mul_owner_o,
    input  logic                     mul_done_i,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     overrun_o,
    output logic                     timeout_o,
    input  logic                     err_clr_i
);

    localparam int TW    = $clog2(ENV_TIMEOUT);
    localparam int NSLOT = 1 << VOICE_IDX_W;
    localparam int FW    = 4 * NSLOT;

    frame_state_e           state, state_n;
    logic [VOICE_IDX_W-1:0] voice;
    logic [TW-1:0]          tcnt;
    logic [NUM_VOICES-1:0]  gate_q;
    logic                   last_voice, expired, advance;
    logic [NSLOT-1:0]       gate_pad;
    logic [FW-1:0]          att_pad, dec_pad, sus_pad, rel_pad;

    assign last_voice = (voice == VOICE_IDX_W'(NUM_VOICES - 1));
    assign expired    = (tcnt == TW'(ENV_TIMEOUT - 1));
    assign advance    = (state == WAIT) && (env_ready_i || expired);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (sample_tick_i) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (advance) state_n = last_voice ? DONE : START;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            voice     <= '0;
            tcnt      <= '0;
            gate_q    <= '0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && sample_tick_i) begin
                gate_q <= gate_i;
                voice  <= '0;
            end
            if (state == START)                tcnt <= '0;
            else if (state == WAIT && !expired) tcnt <= tcnt + 1'b1;
            if (advance && !last_voice) voice <= voice + 1'b1;
            // Set events take priority over the clear.
            if (sample_tick_i && state != IDLE) overrun_o <= 1'b1;
            else if (err_clr_i)                 overrun_o <= 1'b0;
            if (state == WAIT && expired && !env_ready_i) timeout_o <= 1'b1;
            else if (err_clr_i)                          timeout_o <= 1'b0;
        end
    end

    // Zero-pad so a 2-bit voice index never selects past the packed inputs.
    assign gate_pad = NSLOT'(gate_q);
    assign att_pad  = FW'(attack_i);
    assign dec_pad  = FW'(decay_i);
    assign sus_pad  = FW'(sustain_i);
    assign rel_pad  = FW'(release_i);

    assign busy_o        = (state != IDLE);
    assign env_start_o   = (state == START);
    assign frame_done_o  = (state == DONE);
    assign env_voice_o   = voice;
    assign env_gate_o    = busy_o & gate_pad[voice];
    assign env_attack_o  = busy_o ? att_pad[{voice, 2'b00} +: 4] : 4'h0;
    assign env_decay_o   = busy_o ? dec_pad[{voice, 2'b00} +: 4] : 4'h0;
    assign env_sustain_o = busy_o ? sus_pad[{voice, 2'b00} +: 4] : 4'h0;
    assign env_release_o = busy_o ? rel_pad[{voice, 2'b00} +: 4] : 4'h0;

    mul_arbiter u_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .env_req   (env_mult_req_i),
        .aux_req   (aux_mult_req_i),
        .mul_done  (mul_done_i),
        .env_ready (env_mult_ready_o),
        .aux_ready (aux_mult_ready_o),
        .mul_start (mul_start_o),
        .mul_owner (mul_owner_o)
    );

endmodule
